// File: rtl/switch_select_controller.sv
// ============================================================================
// switch_select_controller
// ----------------------------------------------------------------------------
// Sequences the slide-switch -> LED selection path of the home simulation.
//   * The raw switches pass through a 2-flop synchroniser. One shared counter
//     then debounces the whole switch vector.
//   * The controller arbitrates among the raised (debounced) switches. It
//     offers one appliance index to the simulation core over a valid/ack
//     handshake.
//   * It drives LEDR. Every raised switch is lit. The granted switch blinks
//     while it is held after acknowledge.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : the winner is the first raised switch above the last
//               acknowledged index, wrapping modulo N_SW.
//   undefined : fixed priority. The lowest raised index wins.
//
// Ports
//   CLOCK_50   in   1     system clock
//   reset      in   1     asynchronous, active-high reset
//   SW         in   N_SW  raw slide switches (asynchronous to CLOCK_50)
//   sel_ack    in   1     core accepts the current selection
//   sel_valid  out  1     selection presented
//   sel_idx    out  IDXW  index of the selected switch (zero-extended)
//   sw_stable  out  N_SW  debounced switch vector
//   LEDR       out  N_SW  LED drive (registered)
//   state_o    out  2     controller state (0 IDLE, 1 PRESENT, 2 HOLD)
//
// Handshake: sel_valid is high exactly while the controller is in PRESENT.
// While sel_valid is high, sel_idx does not change. The only exceptions are
// an accepted transfer or a withdrawal of the presented switch. A transfer
// happens on a rising CLOCK_50 edge when sel_valid and sel_ack are both high.
// The controller ignores sel_ack while sel_valid is low.
// ============================================================================
module switch_select_controller #(
    parameter int N_SW            = 10,
    parameter int IDXW            = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N_SW-1:0] SW,
    input  logic            sel_ack,
    output logic            sel_valid,
    output logic [IDXW-1:0] sel_idx,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] LEDR,
    output logic [1:0]      state_o
);

    // ------------------------------------------------------------------------
    // Widths
    // ------------------------------------------------------------------------
    // Internal index width is just wide enough to address N_SW switches.
    // The clamps to 1 keep degenerate parameter values legal.
    localparam int IB  = (N_SW > 1)            ? $clog2(N_SW)            : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BLW = (BLINK_CYCLES > 1)    ? $clog2(BLINK_CYCLES)    : 1;

    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLW-1:0] BL_MAX = BLW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------------
    logic [N_SW-1:0] sw_meta_q;
    logic [N_SW-1:0] sw_sync_q;
    logic [N_SW-1:0] sw_prev_q;   // sw_sync_q one cycle ago, for change detection

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_prev_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            sw_prev_q <= sw_sync_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: one counter for the whole vector.
    // The counter only advances while the synchronised value differs from the
    // accepted value and has not moved since the previous cycle. Any
    // movement, on any bit, starts the wait over.
    // ------------------------------------------------------------------------
    logic [DBW-1:0]  db_cnt_q, db_cnt_d;
    logic [N_SW-1:0] sw_stable_q, sw_stable_d;

    always_comb begin
        db_cnt_d    = db_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_sync_q == sw_stable_q) begin
            db_cnt_d = '0;
        end else if (sw_sync_q != sw_prev_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            sw_stable_d = sw_sync_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            db_cnt_q    <= '0;
            sw_stable_q <= '0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            sw_stable_q <= sw_stable_d;
        end
    end

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [IB-1:0]   sel_idx_q, sel_idx_d;
    logic [IB-1:0]   low_idx;      // lowest raised index
    logic [IB-1:0]   winner;
    logic            any_set;
    logic            sel_bit;      // is the currently selected switch still up?

    assign any_set = |sw_stable_q;
    assign sel_bit = sw_stable_q[sel_idx_q];

    // Scan downwards so that the last hit is the lowest index.
    always_comb begin
        low_idx = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (sw_stable_q[i]) begin
                low_idx = IB'(i);
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [IB-1:0] last_grant_q, last_grant_d;
    logic [IB-1:0] above_idx;
    logic          above_found;

    // Look first for the lowest raised index strictly above the last grant.
    // If there is none, wrap around to the lowest raised index overall.
    always_comb begin
        above_idx   = '0;
        above_found = 1'b0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (sw_stable_q[i] && (i > int'(last_grant_q))) begin
                above_idx   = IB'(i);
                above_found = 1'b1;
            end
        end
        winner = above_found ? above_idx : low_idx;
    end

    // The reset value N_SW-1 makes the first grant the lowest raised index.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_grant_q <= IB'(N_SW - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign winner = low_idx;
`endif

    // ------------------------------------------------------------------------
    // Selection FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
`ifdef ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_set) begin
                    state_d   = ST_PRESENT;
                    sel_idx_d = winner;
                end
            end
            ST_PRESENT: begin
                // If the ack and the drop of the switch arrive in the same
                // cycle, the ack wins. HOLD then sees the drop one cycle later.
                if (sel_ack) begin
                    state_d = ST_HOLD;
`ifdef ROUND_ROBIN_EN
                    last_grant_d = sel_idx_q;
`endif
                end else if (!sel_bit) begin
                    if (any_set) begin
                        sel_idx_d = winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // HOLD waits only for the held switch to drop. Other switches
                // that rise meanwhile are picked up after the release.
                if (!sel_bit) begin
                    if (any_set) begin
                        state_d   = ST_PRESENT;
                        sel_idx_d = winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Blink timer. It restarts on each entry into HOLD, so the held LED is
    // always lit for the first full half-period.
    // ------------------------------------------------------------------------
    logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (state_q == ST_HOLD) begin
            if (blink_cnt_q == BL_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // ------------------------------------------------------------------------
    // LED drive, registered one cycle behind state and sw_stable
    // ------------------------------------------------------------------------
    logic [N_SW-1:0] led_q, led_d;

    always_comb begin
        led_d = sw_stable_q;
        if (state_q == ST_HOLD) begin
            led_d[sel_idx_q] = blink_phase_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sel_valid = (state_q == ST_PRESENT);
    assign sel_idx   = IDXW'(sel_idx_q);
    assign sw_stable = sw_stable_q;
    assign LEDR      = led_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_switch_select_controller.sv
// ============================================================================
// tb_switch_select_controller
// Directed bench for switch_select_controller, built with DEBOUNCE_CYCLES=4,
// BLINK_CYCLES=8 and N_SW=10. All inputs change 1 time unit after a rising
// clock edge. All outputs are sampled at that same point.
// A new SW value is accepted into sw_stable on the 7th edge after it is
// driven. The FSM reacts on the 8th edge.
// ============================================================================
module tb_switch_select_controller;

    localparam int N_SW = 10;
    localparam int IDXW = 4;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            rst;
    logic [N_SW-1:0] sw;
    logic            sel_ack;
    logic            sel_valid;
    logic [IDXW-1:0] sel_idx;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] ledr;
    logic [1:0]      state;

    always #5 clk = ~clk;

    switch_select_controller #(
        .N_SW           (N_SW),
        .IDXW           (IDXW),
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .SW       (sw),
        .sel_ack  (sel_ack),
        .sel_valid(sel_valid),
        .sel_idx  (sel_idx),
        .sw_stable(sw_stable),
        .LEDR     (ledr),
        .state_o  (state)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [N_SW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        sel_ack = 1'b1;
        tick(1);
        sel_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        sw      = '0;
        sel_ack = 1'b0;
        #12;
        check_eq("rst_valid", 32'(sel_valid), 32'd0);
        check_eq("rst_idx",   32'(sel_idx),   32'd0);
        check_eq("rst_stable", 32'(sw_stable), 32'd0);
        check_eq("rst_ledr",  32'(ledr),      32'd0);
        check_eq("rst_state", 32'(state),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // --- Glitching switch, then steady ---------------------------------
        sw = 10'h004; tick(2);
        sw = 10'h000; tick(2);
        sw = 10'h004; tick(2);
        sw = 10'h000; tick(2);
        check_eq("glitch_stable", 32'(sw_stable), 32'd0);
        sw = 10'h004;
        tick(6);
        check_eq("db_early", 32'(sw_stable), 32'h000);
        tick(1);
        check_eq("db_accept", 32'(sw_stable), 32'h004);
        check_eq("db_valid_lag", 32'(sel_valid), 32'd0);
        tick(1);
        check_eq("pres_valid", 32'(sel_valid), 32'd1);
        check_eq("pres_idx",   32'(sel_idx),   32'd2);
        check_eq("pres_ledr",  32'(ledr),      32'h004);

        // --- Asynchronous reset while PRESENT --------------------------------
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_valid",  32'(sel_valid), 32'd0);
        check_eq("async_ledr",   32'(ledr),      32'd0);
        check_eq("async_stable", 32'(sw_stable), 32'd0);
        check_eq("async_state",  32'(state),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(7);
        check_eq("rdb_stable", 32'(sw_stable), 32'h004);
        check_eq("rdb_valid0", 32'(sel_valid), 32'd0);
        tick(1);
        check_eq("rdb_valid1", 32'(sel_valid), 32'd1);
        check_eq("rdb_idx",    32'(sel_idx),   32'd2);
        check_eq("rdb_ledr",   32'(ledr),      32'h004);

        // --- Ack, then blink while held -------------------------------------
        ack_pulse();
        check_eq("hold_valid", 32'(sel_valid), 32'd0);
        check_eq("hold_state", 32'(state),     32'd2);
        // LED[2] is lit for 8 cycles, dark for 8, then lit again.
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back(((k <= 8) || (k >= 17)) ? 10'h004 : 10'h000);
        end
        for (int k = 1; k <= 17; k++) begin
            logic [N_SW-1:0] e;
            tick(1);
            e = exp_q.pop_front();
            check_eq($sformatf("blink_k%0d", k), 32'(ledr), 32'(e));
        end
        // Another switch rises while held: its LED follows, the FSM ignores it.
        sw = 10'h044;
        tick(8);
        check_eq("hold_other_ledr", 32'(ledr),    32'h040);
        check_eq("hold_other_idx",  32'(sel_idx), 32'd2);
        check_eq("hold_other_st",   32'(state),   32'd2);
        sw = 10'h000;
        tick(9);
        check_eq("rel_state", 32'(state), 32'd0);
        check_eq("rel_ledr",  32'(ledr),  32'd0);

        // --- Two switches, grant, release, re-arbitrate ----------------------
        sw = 10'h0A0;
        tick(8);
        check_eq("two_valid", 32'(sel_valid), 32'd1);
        check_eq("two_idx",   32'(sel_idx),   32'd5);
        ack_pulse();
        sw = 10'h0A1;
        tick(8);
        check_eq("rise_held_st",  32'(state),   32'd2);
        check_eq("rise_held_idx", 32'(sel_idx), 32'd5);
        sw = 10'h081;
        tick(8);
        check_eq("rearb_state", 32'(state),   32'd1);
        check_eq("rearb_idx",   32'(sel_idx), RR ? 32'd7 : 32'd0);
        ack_pulse();
        sw = RR ? 10'h001 : 10'h080;
        tick(8);
        check_eq("rearb2_idx", 32'(sel_idx), RR ? 32'd0 : 32'd7);
        sw = 10'h000;
        tick(8);
        check_eq("wd_idle", 32'(state), 32'd0);

        // --- Withdrawal without ack, then drop+ack in the same cycle ---------
        sw = 10'h008;
        tick(8);
        check_eq("w_idx3", 32'(sel_idx), 32'd3);
        sw = 10'h208;
        tick(8);
        check_eq("w_idx3_keep", 32'(sel_idx), 32'd3);
        sw = 10'h200;
        tick(7);
        check_eq("w_before_idx", 32'(sel_idx), 32'd3);
        tick(1);
        check_eq("w_after_idx",   32'(sel_idx),   32'd9);
        check_eq("w_after_valid", 32'(sel_valid), 32'd1);
        sw = 10'h000;
        tick(7);
        check_eq("drop_stable", 32'(sw_stable), 32'd0);
        ack_pulse();
        check_eq("dropack_state", 32'(state),     32'd2);
        check_eq("dropack_valid", 32'(sel_valid), 32'd0);
        check_eq("dropack_idx",   32'(sel_idx),   32'd9);
        tick(1);
        check_eq("dropack_idle", 32'(state), 32'd0);

        // --- Ack held high in IDLE and HOLD ---------------------------------
        sel_ack = 1'b1;
        tick(3);
        check_eq("ackidle_state", 32'(state),     32'd0);
        check_eq("ackidle_valid", 32'(sel_valid), 32'd0);
        sw = 10'h002;
        tick(8);
        check_eq("ackhi_pres", 32'(state),   32'd1);
        check_eq("ackhi_idx",  32'(sel_idx), 32'd1);
        tick(1);
        check_eq("ackhi_hold", 32'(state), 32'd2);
        tick(5);
        check_eq("ackhold_state", 32'(state),     32'd2);
        check_eq("ackhold_valid", 32'(sel_valid), 32'd0);
        check_eq("ackhold_idx",   32'(sel_idx),   32'd1);
        sel_ack = 1'b0;
        sw = 10'h000;
        tick(9);
        check_eq("end_state", 32'(state), 32'd0);
        check_eq("end_ledr",  32'(ledr),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
